// File: rtl/rmon_event_counters_pkg.sv
// Shared constants and helpers for the RMON event counter bank.
// Holds the default counter geometry and the read-select width function.
package rmon_pkg;

  localparam int unsigned C_CNT_PP    = 17;
  localparam int unsigned C_CNT_WIDTH = 32;

  // A single counter still needs a one-bit select.
  function automatic int unsigned f_log2_ceil(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rmon_event_counters_if.sv
// Event, clear and readout signals of the RMON counter bank.
// The master drives events and the read select, and the slave returns the registered readout.
interface rmon_event_counters_if #(
  parameter int unsigned g_n  = 17,
  parameter int unsigned g_sw = 5,
  parameter int unsigned g_w  = 32
);

  logic [g_n-1:0]  events;
  logic            clr;
  logic [g_sw-1:0] rd_sel;
  logic [g_w-1:0]  rd_val;
  logic            rd_ovf;
  logic            ovf_any;

  modport master (
    output events,
    output clr,
    output rd_sel,
    input  rd_val,
    input  rd_ovf,
    input  ovf_any
  );

  modport slave (
    input  events,
    input  clr,
    input  rd_sel,
    output rd_val,
    output rd_ovf,
    output ovf_any
  );

endinterface

// File: rtl/rmon_event_counters_counter.sv
// One free-running event counter with a sticky wrap flag.
// Reset and clear both take priority over the increment.
module rmon_counter #(
  parameter int unsigned g_cnt_width = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   inc_i,
  output logic [g_cnt_width-1:0] cnt_o,
  output logic                   ovf_o
);

  logic [g_cnt_width-1:0] r_cnt;
  logic                   r_ovf;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (inc_i) begin
      r_cnt <= r_cnt + 1'b1;
      if (&r_cnt) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign cnt_o = r_cnt;
  assign ovf_o = r_ovf;

endmodule

// File: rtl/rmon_event_counters.sv
// RMON reference counter bank: one counter per event bit across all ports, each with a sticky
// overflow flag, plus a registered single-counter readout and a registered overflow summary.
module rmon_event_counters
  import rmon_pkg::*;
#(
  parameter int unsigned g_nports    = 1,
  parameter int unsigned g_cnt_pp    = C_CNT_PP,
  parameter int unsigned g_cnt_width = C_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  rmon_event_counters_if.slave  bus
);

  localparam int unsigned C_N    = g_nports * g_cnt_pp;
  localparam int unsigned C_SW   = f_log2_ceil(C_N);
  localparam int unsigned C_NPAD = 2 ** C_SW;

  if (g_cnt_width < 2 || g_cnt_width > 32) begin : g_bad_width
    $error("rmon_event_counters: g_cnt_width must be in 2..32");
  end

  // Padded up to the full select range so out-of-range selects read constant zero.
  logic [g_cnt_width-1:0] w_cnt [C_NPAD];
  logic [C_NPAD-1:0]      w_ovf;

  for (genvar gi = 0; gi < C_NPAD; gi++) begin : g_cnt
    if (gi < C_N) begin : g_real
      rmon_counter #(
        .g_cnt_width (g_cnt_width)
      ) u_counter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (bus.clr),
        .inc_i (bus.events[gi]),
        .cnt_o (w_cnt[gi]),
        .ovf_o (w_ovf[gi])
      );
    end else begin : g_pad
      assign w_cnt[gi] = '0;
      assign w_ovf[gi] = 1'b0;
    end
  end

  logic [g_cnt_width-1:0] r_rd_val;
  logic                   r_rd_ovf;
  logic                   r_ovf_any;

  // Readout reflects counter state before this edge's update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_val  <= '0;
      r_rd_ovf  <= 1'b0;
      r_ovf_any <= 1'b0;
    end else begin
      r_rd_val  <= w_cnt[bus.rd_sel];
      r_rd_ovf  <= w_ovf[bus.rd_sel];
      r_ovf_any <= |w_ovf;
    end
  end

  assign bus.rd_val  = r_rd_val;
  assign bus.rd_ovf  = r_rd_ovf;
  assign bus.ovf_any = r_ovf_any;

endmodule

// File: tb/tb_rmon_event_counters.sv
// Directed bench: 8x17x32-bit bank for counting, clear, readout and reset, plus a
// 1x17x4-bit bank for wrap and sticky-overflow behaviour.
module tb_rmon_event_counters;
  import rmon_pkg::*;

  localparam int unsigned N  = 136;
  localparam int unsigned SW = 8;
  localparam int unsigned SN = 17;
  localparam int unsigned SS = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rmon_event_counters_if #(.g_n(N), .g_sw(SW), .g_w(32)) m_bus ();
  rmon_event_counters_if #(.g_n(SN), .g_sw(SS), .g_w(4)) s_bus ();

  rmon_event_counters #(
    .g_nports    (8),
    .g_cnt_pp    (17),
    .g_cnt_width (32)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (m_bus.slave)
  );

  rmon_event_counters #(
    .g_nports    (1),
    .g_cnt_pp    (17),
    .g_cnt_width (4)
  ) u_dut_small (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (s_bus.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned model [N];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m_bus.events = '0;
    m_bus.clr    = 1'b0;
    m_bus.rd_sel = '0;
    s_bus.events = '0;
    s_bus.clr    = 1'b0;
    s_bus.rd_sel = '0;

    // Reset with random events: everything dropped.
    repeat (3) begin
      for (int i = 0; i < int'(N); i++) m_bus.events[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < int'(SN); i++) s_bus.events[i] = 1'($urandom_range(0, 1));
      step();
    end
    chk("rst_rd_val", m_bus.rd_val, 0);
    chk("rst_rd_ovf", {31'd0, m_bus.rd_ovf}, 0);
    chk("rst_ovf_any", {31'd0, m_bus.ovf_any}, 0);
    chk("rst_small_val", {28'd0, s_bus.rd_val}, 0);
    rst = 1'b0;
    m_bus.events = '0;
    s_bus.events = '0;
    foreach (model[i]) model[i] = 0;
    for (int s = 0; s < 136; s += 45) begin
      m_bus.rd_sel = SW'(s);
      step();
      chk($sformatf("rst_cnt%0d", s), m_bus.rd_val, 0);
      chk($sformatf("rst_ovf%0d", s), {31'd0, m_bus.rd_ovf}, 0);
    end
    chk("rst_ovf_any_after", {31'd0, m_bus.ovf_any}, 0);

    // Single event bit 18 for five cycles.
    m_bus.events[18] = 1'b1;
    repeat (5) step();
    m_bus.events = '0;
    m_bus.rd_sel = 8'd18;
    step();
    chk("single_18", m_bus.rd_val, 5);
    m_bus.rd_sel = 8'd17;
    #1;
    chk("single_latency_hold", m_bus.rd_val, 5);
    step();
    chk("single_17", m_bus.rd_val, 0);
    m_bus.rd_sel = 8'd19;
    step();
    chk("single_19", m_bus.rd_val, 0);

    // All bits high for 1000 cycles after a clear.
    m_bus.clr = 1'b1;
    step();
    m_bus.clr = 1'b0;
    m_bus.events = '1;
    repeat (1000) step();
    m_bus.events = '0;
    for (int s = 0; s < 136; s += 27) begin
      m_bus.rd_sel = SW'(s);
      step();
      chk($sformatf("all_%0d", s), m_bus.rd_val, 1000);
    end

    // Random pattern against a per-bit model.
    foreach (model[i]) model[i] = 1000;
    repeat (2000) begin
      for (int i = 0; i < int'(N); i++) begin
        m_bus.events[i] = 1'($urandom_range(0, 1));
        model[i] += 32'(m_bus.events[i]);
      end
      step();
    end
    m_bus.events = '0;
    for (int i = 0; i < int'(N); i++) begin
      m_bus.rd_sel = SW'(i);
      step();
      chk($sformatf("rand_%0d", i), m_bus.rd_val, model[i]);
    end
    chk("rand_ovf_any", {31'd0, m_bus.ovf_any}, 0);

    // Wrap on the 4-bit bank.
    s_bus.rd_sel = '0;
    s_bus.events[0] = 1'b1;
    repeat (15) step();
    s_bus.events = '0;
    step();
    chk("wrap_15_val", {28'd0, s_bus.rd_val}, 15);
    chk("wrap_15_ovf", {31'd0, s_bus.rd_ovf}, 0);
    s_bus.events[0] = 1'b1;
    step();
    s_bus.events = '0;
    chk("wrap_16_any_early", {31'd0, s_bus.ovf_any}, 0);
    step();
    chk("wrap_16_val", {28'd0, s_bus.rd_val}, 0);
    chk("wrap_16_ovf", {31'd0, s_bus.rd_ovf}, 1);
    chk("wrap_16_any", {31'd0, s_bus.ovf_any}, 1);
    s_bus.events[0] = 1'b1;
    step();
    s_bus.events = '0;
    step();
    chk("wrap_17_val", {28'd0, s_bus.rd_val}, 1);
    chk("wrap_17_ovf", {31'd0, s_bus.rd_ovf}, 1);
    s_bus.rd_sel = 5'd1;
    step();
    chk("wrap_other_ovf", {31'd0, s_bus.rd_ovf}, 0);
    s_bus.clr = 1'b1;
    s_bus.rd_sel = '0;
    step();
    s_bus.clr = 1'b0;
    step();
    chk("wrap_clr_ovf", {31'd0, s_bus.rd_ovf}, 0);
    chk("wrap_clr_any", {31'd0, s_bus.ovf_any}, 0);

    // Clear wins over simultaneous events.
    m_bus.clr = 1'b1;
    m_bus.events = '1;
    step();
    m_bus.clr = 1'b0;
    m_bus.events = '0;
    m_bus.events[5] = 1'b1;
    m_bus.rd_sel = 8'd5;
    step();
    chk("clr_zero", m_bus.rd_val, 0);
    m_bus.events = '0;
    step();
    chk("clr_then_event", m_bus.rd_val, 1);
    m_bus.rd_sel = 8'd6;
    step();
    chk("clr_other", m_bus.rd_val, 0);

    // Out-of-range selects read zero even with live counts.
    m_bus.events = '1;
    repeat (3) step();
    m_bus.events = '0;
    m_bus.rd_sel = 8'd0;
    step();
    chk("pre_oor_cnt0", m_bus.rd_val, 3);
    for (int s = 136; s < 256; s++) begin
      m_bus.rd_sel = SW'(s);
      step();
      chk($sformatf("oor_val_%0d", s), m_bus.rd_val, 0);
      chk($sformatf("oor_ovf_%0d", s), {31'd0, m_bus.rd_ovf}, 0);
    end

    // Reset mid-run drops events and clears everything.
    rst = 1'b1;
    m_bus.events = '1;
    m_bus.rd_sel = 8'd5;
    step();
    chk("midrst_rd_val", m_bus.rd_val, 0);
    rst = 1'b0;
    m_bus.events = '0;
    step();
    chk("midrst_cnt5", m_bus.rd_val, 0);
    m_bus.rd_sel = 8'd135;
    step();
    chk("midrst_cnt135", m_bus.rd_val, 0);
    chk("midrst_ovf_any", {31'd0, m_bus.ovf_any}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
